rcc_div_sel_ctrl: RTL

Configuration sequencer directly upstream of the 1/2/4/8/16 dynamic clock divider. It accepts divider-select change requests over a four-phase req/ack handshake and drives the divider's 3-bit `div_sel`. A new value is applied only on an output-period boundary, as signalled by the divider's `div_en`. Acknowledge is withheld until the divider has settled, so software or the RCC FSM never observes a half-switched clock.

---
 rtl/rcc_pkg.sv | 23 ++
 rtl/rcc_div_sel_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rcc_pkg.sv
// Shared RCC definitions: divider-select encodings, sequencer states and
// select normalisation used by every block that talks to the clock divider.
package rcc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_ACK       = 2'd3
  } cfg_state_e;

  localparam logic [2:0] DIV_SEL_1  = 3'b000;
  localparam logic [2:0] DIV_SEL_2  = 3'b100;
  localparam logic [2:0] DIV_SEL_4  = 3'b101;
  localparam logic [2:0] DIV_SEL_8  = 3'b110;
  localparam logic [2:0] DIV_SEL_16 = 3'b111;

  // Every 0xx code means divide-by-1; collapse them to one canonical value.
  function automatic logic [2:0] norm_div_sel(input logic [2:0] sel);
    return sel[2] ? sel : DIV_SEL_1;
  endfunction

endpackage

// File: rtl/rcc_div_sel_ctrl.sv
// Divider-select sequencer: accepts req/ack select changes, applies them on a
// divider period boundary and acknowledges only once the divider has settled.
module rcc_div_sel_ctrl
  import rcc_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned SETTLE_EDGES = 2,
  parameter logic [2:0]  RST_SEL      = 3'b000
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       cfg_req,
  input  logic [2:0] cfg_sel,
  output logic       cfg_ack,
  output logic       cfg_busy,
  output logic       cfg_err,
  input  logic       div_en,
  output logic [2:0] div_sel
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [1:0]    SETTLE_TGT = 2'(SETTLE_EDGES);

  cfg_state_e    state_q, state_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    div_sel_q, div_sel_d;
  logic          err_q, err_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    settle_q, settle_d;

  logic [2:0] sel_n;
  logic [1:0] settle_inc;
  logic       tmo_hit;

  assign sel_n      = norm_div_sel(cfg_sel);
  assign settle_inc = settle_q + 2'd1;
  assign tmo_hit    = (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    div_sel_d = div_sel_q;
    err_d     = err_q;
    settle_d  = settle_q;
    tmo_d     = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_req) begin
          err_d = 1'b0;
          if (sel_n != div_sel_q) begin
            pend_d  = sel_n;
            state_d = ST_WAIT_EDGE;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT_EDGE: begin
        // A real boundary wins over a simultaneous timeout.
        if (div_en) begin
          div_sel_d = pend_q;
          state_d   = ST_SETTLE;
        end else if (tmo_hit) begin
          div_sel_d = pend_q;
          err_d     = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (div_en) begin
          settle_d = settle_inc;
        end
        if (div_en && (settle_inc == SETTLE_TGT)) begin
          state_d = ST_ACK;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!cfg_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Both counters restart on every state entry; the timeout one saturates.
    if (state_d != state_q) begin
      tmo_d    = '0;
      settle_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + TW'(1);
    end

    ack_d  = (state_d == ST_ACK);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= RST_SEL;
      div_sel_q <= RST_SEL;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      div_sel_q <= div_sel_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
    end
  end

  assign cfg_ack  = ack_q;
  assign cfg_busy = busy_q;
  assign cfg_err  = err_q;
  assign div_sel  = div_sel_q;

endmodule
